// File: rtl/block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : block_sequencer
// Description : Walks an enable mask of N_BLOCKS processing blocks and grants
//               a one-hot control enable to one block at a time. It waits for
//               that block's done handshake before moving on. Supported orders
//               are ascending, descending, single-shot (lowest enabled block
//               only) and looping ascending. Each block has a run timeout, and
//               the sequence can be aborted at any point.
// Ports       : clk, reset            clock / async active-high reset
//               start, abort          sequence control
//               blocks[N_BLOCKS]      enable mask, latched on accepted start
//               selector[3]           [1:0] order (latched), [2] live hold
//               block_done[N_BLOCKS]  per-block completion handshake
//               control[N_BLOCKS]     one-hot enable of the active block
//               cur_idx[IDX_W]        active / last-scanned block index
//               busy, done            status (done is a one-cycle pulse)
//               timeout_err           high while in the error state
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module block_sequencer #(
    parameter int N_BLOCKS       = 7,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int IDX_W          = $clog2(N_BLOCKS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [N_BLOCKS-1:0] blocks,
    input  logic [2:0]          selector,
    input  logic [N_BLOCKS-1:0] block_done,
    output logic [N_BLOCKS-1:0] control,
    output logic [IDX_W-1:0]    cur_idx,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);

    localparam logic [1:0] c_MODE_ASC    = 2'd0;
    localparam logic [1:0] c_MODE_DESC   = 2'd1;
    localparam logic [1:0] c_MODE_SINGLE = 2'd2;
    localparam logic [1:0] c_MODE_LOOP   = 2'd3;

    localparam int             c_TMR_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMR_W-1:0] c_TMO = c_TMR_W'(TIMEOUT_CYCLES);
    localparam bit             c_TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              r_state;
    logic [N_BLOCKS-1:0] r_mask;
    logic [1:0]          r_mode;
    logic [IDX_W-1:0]    r_origin;
    // Set when the walk has run off the end of the index range. The sequencer
    // still spends one SCAN cycle, which keeps the delay from the last
    // block_done to the done pulse at two cycles in every mode.
    logic                r_end;
    logic [c_TMR_W-1:0]  r_timer;

    // ------------------------------------------------------------------
    // Next-enabled-block search, starting at r_origin inclusive.
    // ------------------------------------------------------------------
    logic             w_fwd_found, w_bwd_found, w_any_found;
    logic [IDX_W-1:0] w_fwd_idx, w_bwd_idx, w_low_idx;
    logic             w_found;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_hold;

    always_comb begin
        w_fwd_found = 1'b0;
        w_fwd_idx   = '0;
        w_any_found = 1'b0;
        w_low_idx   = '0;
        w_bwd_found = 1'b0;
        w_bwd_idx   = '0;
        // Walking downward leaves the lowest qualifying index as the last write.
        for (int i = N_BLOCKS - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_any_found = 1'b1;
                w_low_idx   = IDX_W'(i);
                if (i >= int'(r_origin)) begin
                    w_fwd_found = 1'b1;
                    w_fwd_idx   = IDX_W'(i);
                end
            end
        end
        // Walking upward leaves the highest qualifying index as the last write.
        for (int i = 0; i < N_BLOCKS; i++) begin
            if (r_mask[i] && (i <= int'(r_origin))) begin
                w_bwd_found = 1'b1;
                w_bwd_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_found   = w_fwd_found;
        w_hit_idx = w_fwd_idx;
        case (r_mode)
            c_MODE_DESC: begin
                w_found   = w_bwd_found;
                w_hit_idx = w_bwd_idx;
            end
            c_MODE_LOOP: begin
                // Nothing left above the origin: wrap to the lowest enabled block.
                w_found   = w_any_found;
                w_hit_idx = w_fwd_found ? w_fwd_idx : w_low_idx;
            end
            default: ;
        endcase
    end

    assign w_hold = selector[2];

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_mode      <= c_MODE_ASC;
            r_origin    <= '0;
            r_end       <= 1'b0;
            r_timer     <= '0;
            control     <= '0;
            cur_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else if (abort) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            control     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        r_mask      <= blocks;
                        r_mode      <= selector[1:0];
                        r_origin    <= (selector[1:0] == c_MODE_DESC) ? c_LAST : '0;
                        r_end       <= 1'b0;
                        r_state     <= S_SCAN;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (!r_end && w_found) begin
                        cur_idx <= w_hit_idx;
                        control <= N_BLOCKS'(1) << w_hit_idx;
                        r_timer <= '0;
                        r_state <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_RUN: begin
                    // Hold freezes the block entirely: no advance, no timer.
                    if (!w_hold) begin
                        if (block_done[cur_idx]) begin
                            control <= '0;
                            r_timer <= '0;
                            r_state <= S_SCAN;
                            case (r_mode)
                                c_MODE_ASC: begin
                                    r_end    <= (cur_idx == c_LAST);
                                    r_origin <= cur_idx + 1'b1;
                                end
                                c_MODE_LOOP: begin
                                    r_origin <= (cur_idx == c_LAST) ? '0 : cur_idx + 1'b1;
                                end
                                c_MODE_DESC: begin
                                    r_end    <= (cur_idx == '0);
                                    r_origin <= cur_idx - 1'b1;
                                end
                                default: r_end <= 1'b1; // single-shot
                            endcase
                        end else if (c_TMO_EN && (r_timer == c_TMO)) begin
                            control     <= '0;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                            r_state     <= S_ERR;
                        end else if (c_TMO_EN) begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    control <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_sequencer
// Description : Self-checking bench for block_sequencer. It drives a
//               cycle-by-cycle vector table against a default instance, then
//               runs directed timeout, hold and reset sequences. The timeout
//               sequence uses a second instance with a short timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_sequencer;

    localparam int N = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, abort, start_t, abort_t;
    logic [N-1:0] blocks, block_done;
    logic [2:0]   selector;

    logic [N-1:0] control, control_t;
    logic [2:0]   cur_idx, cur_idx_t;
    logic         busy, done, timeout_err;
    logic         busy_t, done_t, timeout_err_t;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    block_sequencer #(.N_BLOCKS(N), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .blocks(blocks), .selector(selector), .block_done(block_done),
        .control(control), .cur_idx(cur_idx), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    block_sequencer #(.N_BLOCKS(N), .TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .abort(abort_t),
        .blocks(blocks), .selector(selector), .block_done(block_done),
        .control(control_t), .cur_idx(cur_idx_t), .busy(busy_t), .done(done_t),
        .timeout_err(timeout_err_t)
    );

    typedef struct {
        logic         st;
        logic         ab;
        logic [2:0]   sel;
        logic [N-1:0] blk;
        logic [N-1:0] bd;
        logic [N-1:0] e_ctrl;
        logic [2:0]   e_idx;
        logic         e_busy;
        logic         e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic ab, input logic [2:0] sel,
                       input logic [N-1:0] blk, input logic [N-1:0] bd,
                       input logic [N-1:0] e_ctrl, input logic [2:0] e_idx,
                       input logic e_busy, input logic e_done);
        vec_t v;
        v.st = st; v.ab = ab; v.sel = sel; v.blk = blk; v.bd = bd;
        v.e_ctrl = e_ctrl; v.e_idx = e_idx; v.e_busy = e_busy; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock, then sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {control, cur_idx, busy, done, timeout_err}
    function automatic logic [31:0] pack_main();
        return {19'd0, control, cur_idx, busy, done, timeout_err};
    endfunction

    initial begin
        int cnt;
        int bad;

        reset = 1'b1; start = 0; abort = 0; start_t = 0; abort_t = 0;
        blocks = '0; block_done = '0; selector = '0;

        // Columns: start abort sel blocks block_done | control idx busy done
        // Ascending over 0010101; block_done 3 cycles into each grant.
        add(1,0,3'd0,7'b0010101,7'b0000000, 7'b0000000,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000001,3'd0,1,0); // mask change ignored
        add(1,0,3'd0,7'b0000000,7'b0000000, 7'b0000001,3'd0,1,0); // start in RUN ignored
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000001,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000001, 7'b0000000,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000100,3'd2,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000001, 7'b0000100,3'd2,1,0); // inactive done ignored
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000100,3'd2,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000100, 7'b0000000,3'd2,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0010000,3'd4,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0010000,3'd4,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0010000,3'd4,1,0);
        add(0,0,3'd0,7'b0000000,7'b0010000, 7'b0000000,3'd4,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd4,0,1);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd4,0,0);
        // Descending over the same mask
        add(1,0,3'd1,7'b0010101,7'b0000000, 7'b0000000,3'd4,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0010000,3'd4,1,0); // mode change ignored
        add(0,0,3'd0,7'b0000000,7'b0010000, 7'b0000000,3'd4,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000100,3'd2,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000100, 7'b0000000,3'd2,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000001,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000001, 7'b0000000,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd0,0,1);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd0,0,0);
        // Empty mask: one busy cycle, then a done pulse
        add(1,0,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd0,0,1);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd0,0,0);
        // Loop over 1000001: 0,6,0,6,0, then abort during RUN
        add(1,0,3'd3,7'b1000001,7'b0000000, 7'b0000000,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000001,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000001, 7'b0000000,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b1000000,3'd6,1,0);
        add(0,0,3'd0,7'b0000000,7'b1000000, 7'b0000000,3'd6,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000001,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000001, 7'b0000000,3'd0,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b1000000,3'd6,1,0);
        add(0,0,3'd0,7'b0000000,7'b1000000, 7'b0000000,3'd6,1,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000001,3'd0,1,0);
        add(0,1,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd0,0,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd0,0,0);
        // Abort wins over start
        add(1,1,3'd0,7'b0000001,7'b0000000, 7'b0000000,3'd0,0,0);
        add(0,0,3'd0,7'b0000000,7'b0000000, 7'b0000000,3'd0,0,0);

        // Reset state of both instances
        repeat (2) step();
        check("reset_main", pack_main(), 32'd0);
        check("reset_t", {19'd0, control_t, cur_idx_t, busy_t, done_t, timeout_err_t}, 32'd0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            start      = vecs[i].st;
            abort      = vecs[i].ab;
            selector   = vecs[i].sel;
            blocks     = vecs[i].blk;
            block_done = vecs[i].bd;
            step();
            check($sformatf("vec%0d", i), pack_main(),
                  {19'd0, vecs[i].e_ctrl, vecs[i].e_idx, vecs[i].e_busy, vecs[i].e_done, 1'b0});
        end
        start = 0; abort = 0; selector = '0; blocks = '0; block_done = '0;

        // Timeout (TIMEOUT_CYCLES = 4) on block 1, never answered
        blocks = 7'b0000010; start_t = 1'b1;
        step();
        start_t = 1'b0; blocks = '0;
        step();
        check("tmo_grant", {25'd0, control_t}, {25'd0, 7'b0000010});
        cnt = 0;
        while (!timeout_err_t && cnt < 20) begin
            step();
            cnt++;
        end
        check("tmo_latency", cnt, 32'd5);
        check("tmo_err_state", {19'd0, control_t, cur_idx_t, busy_t, done_t, timeout_err_t},
              {19'd0, 7'b0000000, 3'd1, 1'b0, 1'b0, 1'b1});
        blocks = 7'b0000010; start_t = 1'b1;
        step();
        start_t = 1'b0; blocks = '0;
        check("tmo_restart", {30'd0, busy_t, timeout_err_t}, {30'd0, 1'b1, 1'b0});
        step();
        check("tmo_regrant", {25'd0, control_t}, {25'd0, 7'b0000010});
        abort_t = 1'b1;
        step();
        abort_t = 1'b0;
        check("tmo_abort", {24'd0, control_t, busy_t}, 32'd0);

        // Hold for 300 cycles with block_done high, then release
        blocks = 7'b0000011; selector = 3'b000; start = 1'b1;
        step();
        start = 1'b0; blocks = '0;
        step();
        check("hold_grant", {25'd0, control}, {25'd0, 7'b0000001});
        selector = 3'b100; block_done = 7'b0000001;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (control !== 7'b0000001 || timeout_err !== 1'b0) bad++;
        end
        check("hold_frozen", bad, 32'd0);
        selector = 3'b000;
        step();
        block_done = '0;
        check("hold_release", {24'd0, control, busy}, {24'd0, 7'b0000000, 1'b1});
        step();
        check("hold_advance", {22'd0, control, cur_idx}, {22'd0, 7'b0000010, 3'd1});

        // Asynchronous reset in the middle of RUN
        #2 reset = 1'b1;
        #1;
        check("async_reset", pack_main(), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("post_reset_idle", pack_main(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
